clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Parametrised, runtime-programmable clock divider. It is the successor to the fixed 100 MHz -> 66.67 kHz toggle divider used for the PmodJSTK SPI interface.
- Generates a divided clock CLK_O, a one-cycle clock-enable TICK, and one-cycle RISE_STB / FALL_STB edge strobes, so downstream SPI logic can run on the system clock.
- The half-period is set at elaboration by parameter and can be reloaded at runtime without glitches. EN and SYNC give gating and phase restart.

Parameters:
- DIV_W, 10, width of the half-period count and of HALF_IN.
- HALF_DEF, 750, half-period in CLK cycles after reset. 100 MHz / (2*750) = 66.67 kHz. Must satisfy 1 <= HALF_DEF <= 2^DIV_W-1.
- IDLE_LVL, 0, level of CLK_O during reset, while EN=0, and after SYNC.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  reset, synchronous, active-low (0 = reset).
- EN  input  1  run enable; 0 = counter cleared and CLK_O parked at IDLE_LVL.
- SYNC  input  1  one-cycle phase restart.
- LOAD  input  1  one-cycle strobe; captures HALF_IN as the new half-period.
- HALF_IN  input  DIV_W  requested half-period in CLK cycles.
- CLK_O  output  1  divided clock, registered, period 2*half.
- TICK  output  1  one-cycle pulse on every CLK_O toggle.
- RISE_STB  output  1  high for exactly the cycle in which CLK_O first reads 1 after a 0->1 toggle.
- FALL_STB  output  1  high for exactly the cycle in which CLK_O first reads 0 after a 1->0 toggle.
- HALF_CUR  output  DIV_W  half-period currently in effect.

Behaviour:
- Reset (RST=0 at an edge):
  - cnt=0, half_cur=HALF_DEF, pend=0, CLK_O=IDLE_LVL.
  - TICK=RISE_STB=FALL_STB=0, HALF_CUR=HALF_DEF.
- Priority each edge: RST > EN=0 > SYNC > normal count. LOAD is evaluated in every non-reset cycle, independent of this chain.
- Normal (EN=1, SYNC=0):
  - If cnt==half_cur-1: cnt<=0, CLK_O<=~CLK_O, TICK<=1, RISE_STB<=~CLK_O, FALL_STB<=CLK_O.
  - Otherwise: cnt<=cnt+1 and all strobes 0.
- Timing:
  - First toggle lands on the half_cur-th edge with EN=1 after reset, EN rise or SYNC.
  - Output period is exactly 2*half_cur cycles; duty is exactly 50% for any half.
  - half_cur=1: CLK_O toggles every cycle, TICK stays high continuously, RISE_STB/FALL_STB alternate.
- Strobes are registered together with CLK_O, so there is no extra latency relative to CLK_O.
- LOAD:
  - Value is clamped: HALF_IN==0 is treated as 1.
  - Sets pend=1 and half_pend=clamped value. A later LOAD before application overwrites it (last wins).
- Applying the pending value:
  - Applied only at a period boundary: the wrap cycle (cnt==half_cur-1), or any cycle with EN=0 or SYNC=1. Then half_cur<=half_pend and pend<=0.
  - The in-progress half-period is never shortened or stretched; no runt pulses.
- LOAD in the same cycle as a boundary: the clamped HALF_IN bypasses the pending register and becomes half_cur immediately; pend ends 0.
- EN=0:
  - cnt<=0, CLK_O<=IDLE_LVL, strobes 0, pending value applied.
  - No TICK and no edge strobe are generated for the forced park, even if CLK_O changes level.
- SYNC (EN=1): cnt<=0, CLK_O<=IDLE_LVL, strobes 0, pending value applied; counting resumes next cycle.
- HALF_CUR mirrors half_cur, updating on the same edge that half_cur changes.
- Reset mid-period discards cnt, the pending value and CLK_O phase with no strobe; after reset the block resumes with HALF_DEF.
- Width: cnt and half registers are DIV_W bits. cnt never exceeds half_cur-1, so there is no wrap-around overflow.

Test Plan:
- Reset, defaults: HALF_DEF=3, IDLE_LVL=0, EN=1 from the first edge after reset release -> CLK_O goes 0,0,1 (rises on edge 3), falls on edge 6, period 6. TICK high on edges 3,6,9…; RISE_STB only on 3,9; FALL_STB only on 6,12.
- LOAD mid-period: HALF_IN=5 pulsed when cnt=0 -> current half completes at 3 cycles, then half-periods are 5. HALF_CUR changes 3->5 on the wrap edge. No half-period other than 3 or 5 is ever observed.
- LOAD in the wrap cycle plus overwrite: LOAD HALF_IN=2 in the wrap cycle -> the next half-period is 2. Two LOADs, 4 then 7, before a boundary -> 7 is applied and 4 never appears.
- HALF_IN=0 and half=1: LOAD 0 -> HALF_CUR=1, CLK_O toggles every cycle, TICK constant 1, RISE_STB/FALL_STB alternate each cycle.
- EN/SYNC: EN dropped with CLK_O=1 -> next edge CLK_O=0, no FALL_STB. EN re-raised -> first rise exactly half_cur edges later. SYNC pulse mid-period -> same restart behaviour, with the pending LOAD applied.
- Reset mid-operation: RST=0 for 1 cycle with half=5 and a pending value -> all outputs at reset values, HALF_CUR=3, pending value discarded.

Source files
------------

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//   Runtime-programmable clock divider. It produces a registered 50%-duty
//   divided clock together with a one-cycle TICK on every toggle and
//   one-cycle RISE_STB / FALL_STB strobes. All outputs are registered, so
//   the strobes line up with the cycle in which CLK_O first shows its new
//   level.
//
//   A new half-period can be requested at any time with LOAD. It is held
//   pending and only takes effect at a period boundary, so the half-period
//   currently in progress always completes at its original length.
//
// Parameters
//   DIV_W     width of the half-period counter and of HALF_IN
//   HALF_DEF  half-period (in CLK cycles) after reset, 1 .. 2^DIV_W-1
//   IDLE_LVL  CLK_O level during reset, while EN=0 and after SYNC
//
// Ports
//   CLK       system clock (rising edge)
//   RST       synchronous reset, active low
//   EN        run enable; 0 parks CLK_O at IDLE_LVL and clears the counter
//   SYNC      one-cycle phase restart
//   LOAD      one-cycle strobe capturing HALF_IN
//   HALF_IN   requested half-period (0 is treated as 1)
//   CLK_O     divided clock, period 2*HALF_CUR
//   TICK      one-cycle pulse on every CLK_O toggle
//   RISE_STB  high in the first cycle CLK_O reads 1 after a 0->1 toggle
//   FALL_STB  high in the first cycle CLK_O reads 0 after a 1->0 toggle
//   HALF_CUR  half-period currently in effect
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int DIV_W    = 10,
    parameter int HALF_DEF = 750,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SYNC,
    input  logic             LOAD,
    input  logic [DIV_W-1:0] HALF_IN,
    output logic             CLK_O,
    output logic             TICK,
    output logic             RISE_STB,
    output logic             FALL_STB,
    output logic [DIV_W-1:0] HALF_CUR
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half_cur;
    logic [DIV_W-1:0] half_pend;
    logic             pend;

    logic [DIV_W-1:0] load_val;
    logic             wrap;
    logic             restart;
    logic             boundary;

    // A zero half-period would never wrap; treat it as the fastest rate.
    assign load_val = (HALF_IN == '0) ? DIV_W'(1) : HALF_IN;

    assign wrap     = (cnt == half_cur - DIV_W'(1));
    assign restart  = !EN || SYNC;
    // Points where a new half-period may take over without cutting or
    // stretching the half-period in progress.
    assign boundary = restart || wrap;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt       <= '0;
            half_cur  <= DIV_W'(HALF_DEF);
            half_pend <= '0;
            pend      <= 1'b0;
            CLK_O     <= IDLE_LVL;
            TICK      <= 1'b0;
            RISE_STB  <= 1'b0;
            FALL_STB  <= 1'b0;
        end else begin
            TICK     <= 1'b0;
            RISE_STB <= 1'b0;
            FALL_STB <= 1'b0;

            // Forced park on EN=0 / SYNC deliberately emits no strobes even
            // if CLK_O changes level.
            if (restart) begin
                cnt   <= '0;
                CLK_O <= IDLE_LVL;
            end else if (wrap) begin
                cnt      <= '0;
                CLK_O    <= ~CLK_O;
                TICK     <= 1'b1;
                RISE_STB <= ~CLK_O;
                FALL_STB <= CLK_O;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            // A LOAD coinciding with a boundary bypasses the pending slot.
            if (boundary) begin
                if (LOAD)
                    half_cur <= load_val;
                else if (pend)
                    half_cur <= half_pend;
                pend <= 1'b0;
            end else if (LOAD) begin
                half_pend <= load_val;
                pend      <= 1'b1;
            end
        end
    end

    assign HALF_CUR = half_cur;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
//   Directed bench for clk_div_prog (DIV_W=8, HALF_DEF=3, IDLE_LVL=0).
//   A countdown model (cycles left until the next toggle) predicts every
//   output after each edge; literal expectations pin the model at the
//   interesting points.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int DIV_W = 8;
    localparam int HDEF  = 3;

    logic             CLK = 1'b0;
    logic             RST, EN, SYNC, LOAD;
    logic [DIV_W-1:0] HALF_IN;
    logic             CLK_O, TICK, RISE_STB, FALL_STB;
    logic [DIV_W-1:0] HALF_CUR;

    int errors = 0;
    int checks = 0;

    // model state
    int m_half, m_pend, m_left;
    bit m_pv, m_lvl, m_tick, m_rise, m_fall;

    clk_div_prog #(.DIV_W(DIV_W), .HALF_DEF(HDEF), .IDLE_LVL(1'b0)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .LOAD(LOAD),
        .HALF_IN(HALF_IN), .CLK_O(CLK_O), .TICK(TICK), .RISE_STB(RISE_STB),
        .FALL_STB(FALL_STB), .HALF_CUR(HALF_CUR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One rising edge of the model, from the inputs seen at that edge.
    task automatic model_edge(input bit rst, input bit en, input bit sync,
                              input bit load, input int hin);
        int  clamp;
        bit  bnd;
        clamp  = (hin == 0) ? 1 : hin;
        m_tick = 0; m_rise = 0; m_fall = 0;
        if (!rst) begin
            m_half = HDEF; m_pv = 0; m_lvl = 0; m_left = HDEF;
            return;
        end
        bnd = !en || sync || (m_left == 1);
        if (bnd) begin
            if (load)      m_half = clamp;
            else if (m_pv) m_half = m_pend;
            m_pv = 0;
        end else if (load) begin
            m_pend = clamp; m_pv = 1;
        end
        if (!en || sync) begin
            m_lvl  = 0;
            m_left = m_half;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_lvl  = !m_lvl;
                m_tick = 1;
                m_rise = m_lvl;
                m_fall = !m_lvl;
                m_left = m_half;
            end
        end
    endtask

    // Drive inputs (called at a falling edge), clock once, compare at the
    // following falling edge.
    task automatic cyc(input bit rst, input bit en, input bit sync,
                       input bit load, input int hin);
        RST = rst; EN = en; SYNC = sync; LOAD = load; HALF_IN = DIV_W'(hin);
        @(posedge CLK);
        model_edge(rst, en, sync, load, hin);
        @(negedge CLK);
        chk("clk_o",    CLK_O,    m_lvl);
        chk("tick",     TICK,     m_tick);
        chk("rise_stb", RISE_STB, m_rise);
        chk("fall_stb", FALL_STB, m_fall);
        chk("half_cur", HALF_CUR, m_half);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0);
    endtask

    // Advance until the next edge is a wrap edge (bounded).
    task automatic to_wrap();
        int guard = 0;
        while (m_left != 1 && guard < 300) begin
            cyc(1, 1, 0, 0, 0);
            guard++;
        end
        chk("to_wrap_bound", (m_left == 1), 1);
    endtask

    task automatic to_high();
        int guard = 0;
        while (!m_lvl && guard < 300) begin
            cyc(1, 1, 0, 0, 0);
            guard++;
        end
        chk("to_high_bound", m_lvl, 1);
    endtask

    initial begin
        RST = 0; EN = 0; SYNC = 0; LOAD = 0; HALF_IN = '0;
        m_half = HDEF; m_pend = 0; m_left = HDEF; m_pv = 0; m_lvl = 0;

        // reset state
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("rst_clk_o", CLK_O, 0);
        chk("rst_half",  HALF_CUR, 3);
        chk("rst_tick",  TICK, 0);

        // defaults: rise on edge 3, fall on 6, period 6
        cyc(1, 1, 0, 0, 0); chk("e1_clk", CLK_O, 0);
        cyc(1, 1, 0, 0, 0); chk("e2_clk", CLK_O, 0);
        cyc(1, 1, 0, 0, 0); chk("e3_clk", CLK_O, 1); chk("e3_rise", RISE_STB, 1);
        run(2);             chk("e5_tick", TICK, 0);
        cyc(1, 1, 0, 0, 0); chk("e6_fall", FALL_STB, 1); chk("e6_rise", RISE_STB, 0);
        run(3);             chk("e9_rise", RISE_STB, 1);
        run(3);             chk("e12_fall", FALL_STB, 1); chk("e12_clk", CLK_O, 0);

        // LOAD 5 at cnt=0: current half completes at 3
        cyc(1, 1, 0, 1, 5); chk("ld5_hold", HALF_CUR, 3);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0); chk("ld5_apply", HALF_CUR, 5); chk("ld5_clk", CLK_O, 1);

        // two LOADs before the boundary: last one wins
        cyc(1, 1, 0, 1, 4);
        cyc(1, 1, 0, 1, 7);
        run(2);             chk("ow_hold", HALF_CUR, 5); chk("ow_clk", CLK_O, 1);
        cyc(1, 1, 0, 0, 0); chk("ow_apply", HALF_CUR, 7); chk("ow_fall", FALL_STB, 1);
        run(6);             chk("h7_clk", CLK_O, 0);
        cyc(1, 1, 0, 0, 0); chk("h7_rise", RISE_STB, 1);

        // LOAD in the wrap cycle bypasses the pending slot
        to_wrap();
        cyc(1, 1, 0, 1, 2); chk("wrap_ld", HALF_CUR, 2); chk("wrap_tick", TICK, 1);
        cyc(1, 1, 0, 0, 0); chk("h2_mid", TICK, 0);
        cyc(1, 1, 0, 0, 0); chk("h2_tick", TICK, 1);

        // LOAD 0 -> half 1: toggles every cycle
        cyc(1, 1, 0, 1, 0); chk("z_hold", HALF_CUR, 2);
        cyc(1, 1, 0, 0, 0); chk("z_apply", HALF_CUR, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0, 0, 0);
            chk("h1_tick", TICK, 1);
        end
        // every edge is a wrap at half 1, so this applies at once
        cyc(1, 1, 0, 1, 3); chk("back3", HALF_CUR, 3);

        // EN dropped while high: park with no strobes
        to_high();
        cyc(1, 0, 0, 0, 0);
        chk("en0_clk", CLK_O, 0); chk("en0_fall", FALL_STB, 0); chk("en0_tick", TICK, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0); chk("enr_1", CLK_O, 0);
        cyc(1, 1, 0, 0, 0); chk("enr_2", CLK_O, 0);
        cyc(1, 1, 0, 0, 0); chk("enr_3", CLK_O, 1); chk("enr_rise", RISE_STB, 1);

        // SYNC mid-period applies a pending LOAD
        run(4);
        cyc(1, 1, 0, 1, 5);
        cyc(1, 1, 1, 0, 0); chk("sync_half", HALF_CUR, 5); chk("sync_clk", CLK_O, 0);
        chk("sync_tick", TICK, 0);
        run(4);             chk("sync_4", CLK_O, 0);
        cyc(1, 1, 0, 0, 0); chk("sync_rise", RISE_STB, 1);

        // reset mid-operation discards the pending value
        run(2);
        cyc(1, 1, 0, 1, 9);
        cyc(0, 1, 0, 0, 0); chk("mr_half", HALF_CUR, 3); chk("mr_clk", CLK_O, 0);
        run(2);             chk("mr_2", CLK_O, 0);
        cyc(1, 1, 0, 0, 0); chk("mr_rise", RISE_STB, 1);
        run(3);             chk("mr_fall", FALL_STB, 1); chk("mr_keep", HALF_CUR, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
